// File: rtl/ballot_memory_bank_pkg.sv
// evm_pkg: shared defaults and saturating-max helper for the ballot memory bank
package evm_pkg;
  localparam int DEF_N_CAND = 8;
  localparam int DEF_CAND_W = 4;
  localparam int DEF_COUNT_W = 8;
  function automatic logic [31:0] sat_max(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/ballot_memory_bank_vote_counter.sv
// vote_counter: saturating per-candidate vote counter with sync clear
module vote_counter
  import evm_pkg::*;
#(
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [COUNT_W-1:0] count,
  output logic               at_max
);
  localparam logic [COUNT_W-1:0] MAX = COUNT_W'(sat_max(COUNT_W));
  assign at_max = count == MAX;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (inc && !at_max) count <= count + COUNT_W'(1);
endmodule

// File: rtl/ballot_memory_bank.sv
// ballot_memory_bank: edge-detected vote capture into saturating per-candidate counters
module ballot_memory_bank
  import evm_pkg::*;
#(
  parameter int N_CAND = DEF_N_CAND,
  parameter int CAND_W = DEF_CAND_W,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic                      clk,
  input  logic                      initializer,
  input  logic                      clear,
  input  logic                      enable,
  input  logic [CAND_W-1:0]         candidate_number,
  input  logic                      vote_cast,
  output logic                      vote_ack,
  output logic                      vote_reject,
  input  logic [CAND_W-1:0]         rd_addr,
  output logic [COUNT_W-1:0]        rd_count,
  output logic [COUNT_W+CAND_W-1:0] total_votes,
  output logic                      saturated
);
  localparam int SLOTS = 2 ** CAND_W;
  logic [COUNT_W-1:0] counts [SLOTS];
  logic [SLOTS-1:0] valid, at_max;
  logic cast_q, armed, req, open, accept, sat_hit;
  assign req = vote_cast && !cast_q && armed;
  assign open = req && enable && !clear && valid[candidate_number];
  assign accept = open && !at_max[candidate_number];
  assign sat_hit = open && at_max[candidate_number];
  genvar i;
  generate
    for (i = 0; i < SLOTS; i++) begin : g_slot
      if (i < N_CAND) begin : g_cnt
        assign valid[i] = 1'b1;
        vote_counter #(.COUNT_W(COUNT_W)) u_cnt (
          .clk(clk),
          .rst(initializer),
          .inc(accept && candidate_number == CAND_W'(i)),
          .clr(clear),
          .count(counts[i]),
          .at_max(at_max[i])
        );
      end else begin : g_pad
        assign valid[i] = 1'b0;
        assign at_max[i] = 1'b0;
        assign counts[i] = '0;
      end
    end
  endgenerate
  always_ff @(posedge clk or posedge initializer)
    if (initializer) begin
      cast_q <= 1'b0;
      armed <= 1'b0;
      vote_ack <= 1'b0;
      vote_reject <= 1'b0;
      rd_count <= '0;
      total_votes <= '0;
      saturated <= 1'b0;
    end else begin
      cast_q <= vote_cast;
      armed <= armed || !vote_cast;
      vote_ack <= accept;
      vote_reject <= req && !accept;
      rd_count <= counts[rd_addr];
      total_votes <= clear ? '0 : accept ? total_votes + (COUNT_W+CAND_W)'(1) : total_votes;
      saturated <= clear ? 1'b0 : saturated || sat_hit;
    end
endmodule

// File: tb/tb_ballot_memory_bank.sv
// tb_ballot_memory_bank: directed vector bench for the ballot memory bank
module tb_ballot_memory_bank;
  localparam int N_CAND = 8;
  localparam int CAND_W = 4;
  localparam int COUNT_W = 4;
  logic clk = 1'b0, initializer = 1'b1, clear = 1'b0, enable = 1'b0, vote_cast = 1'b0;
  logic [CAND_W-1:0] candidate_number = '0, rd_addr = '0;
  logic vote_ack, vote_reject, saturated;
  logic [COUNT_W-1:0] rd_count;
  logic [COUNT_W+CAND_W-1:0] total_votes;
  int errors = 0, checks = 0, acks;
  typedef struct {
    logic en;
    logic [3:0] cand;
    logic [3:0] ra;
    logic ack;
    logic rej;
    int total;
    int rd;
  } vec_t;
  vec_t vecs [8];
  ballot_memory_bank #(.N_CAND(N_CAND), .CAND_W(CAND_W), .COUNT_W(COUNT_W)) dut (
    .clk(clk),
    .initializer(initializer),
    .clear(clear),
    .enable(enable),
    .candidate_number(candidate_number),
    .vote_cast(vote_cast),
    .vote_ack(vote_ack),
    .vote_reject(vote_reject),
    .rd_addr(rd_addr),
    .rd_count(rd_count),
    .total_votes(total_votes),
    .saturated(saturated)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic vote(input logic en, input logic [3:0] cand, input logic clr, input logic [3:0] ra,
                      input logic exp_ack, input logic exp_rej, input int exp_total, input int exp_rd,
                      input string tag);
    @(negedge clk);
    enable = en;
    candidate_number = cand;
    clear = clr;
    rd_addr = ra;
    vote_cast = 1'b1;
    @(negedge clk);
    chk({tag, " ack"}, 32'(vote_ack), 32'(exp_ack));
    chk({tag, " reject"}, 32'(vote_reject), 32'(exp_rej));
    vote_cast = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    chk({tag, " ack width"}, 32'(vote_ack), 32'd0);
    chk({tag, " reject width"}, 32'(vote_reject), 32'd0);
    chk({tag, " total"}, 32'(total_votes), 32'(exp_total));
    chk({tag, " rd_count"}, 32'(rd_count), 32'(exp_rd));
  endtask
  initial begin
    vecs[0] = '{1'b1, 4'd3, 4'd3, 1'b1, 1'b0, 1, 1};
    vecs[1] = '{1'b1, 4'd3, 4'd3, 1'b1, 1'b0, 2, 2};
    vecs[2] = '{1'b0, 4'd3, 4'd3, 1'b0, 1'b1, 2, 2};
    vecs[3] = '{1'b1, 4'd9, 4'd9, 1'b0, 1'b1, 2, 0};
    vecs[4] = '{1'b1, 4'd5, 4'd5, 1'b1, 1'b0, 3, 1};
    vecs[5] = '{1'b1, 4'd7, 4'd3, 1'b1, 1'b0, 4, 2};
    vecs[6] = '{1'b1, 4'd8, 4'd8, 1'b0, 1'b1, 4, 0};
    vecs[7] = '{1'b1, 4'd15, 4'd15, 1'b0, 1'b1, 4, 0};
    #1;
    chk("reset ack", 32'(vote_ack), 32'd0);
    chk("reset reject", 32'(vote_reject), 32'd0);
    chk("reset total", 32'(total_votes), 32'd0);
    chk("reset rd_count", 32'(rd_count), 32'd0);
    chk("reset saturated", 32'(saturated), 32'd0);
    @(negedge clk);
    initializer = 1'b0;
    for (int k = 0; k < 8; k++)
      vote(vecs[k].en, vecs[k].cand, 1'b0, vecs[k].ra, vecs[k].ack, vecs[k].rej,
           vecs[k].total, vecs[k].rd, $sformatf("vec%0d", k));
    @(negedge clk);
    enable = 1'b1;
    candidate_number = 4'd1;
    rd_addr = 4'd1;
    vote_cast = 1'b1;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      acks += int'(vote_ack);
    end
    vote_cast = 1'b0;
    @(negedge clk);
    chk("held acks", 32'(acks), 32'd1);
    chk("held total", 32'(total_votes), 32'd5);
    chk("held rd_count", 32'(rd_count), 32'd1);
    for (int k = 0; k < 15; k++)
      vote(1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 6 + k, 1 + k, $sformatf("fill%0d", k));
    chk("sat before full", 32'(saturated), 32'd0);
    vote(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 20, 15, "sat16");
    chk("saturated set", 32'(saturated), 32'd1);
    vote(1'b1, 4'd6, 1'b0, 4'd6, 1'b1, 1'b0, 21, 1, "post_sat");
    chk("saturated sticky", 32'(saturated), 32'd1);
    vote(1'b1, 4'd3, 1'b1, 4'd3, 1'b0, 1'b1, 0, 0, "clear_vote");
    chk("clear saturated", 32'(saturated), 32'd0);
    rd_addr = 4'd0;
    @(negedge clk);
    @(negedge clk);
    chk("clear rd0", 32'(rd_count), 32'd0);
    vote(1'b1, 4'd2, 1'b0, 4'd2, 1'b1, 1'b0, 1, 1, "pre_rst");
    @(negedge clk);
    vote_cast = 1'b1;
    @(posedge clk);
    #2;
    chk("pending ack", 32'(vote_ack), 32'd1);
    initializer = 1'b1;
    #1;
    chk("async ack", 32'(vote_ack), 32'd0);
    chk("async reject", 32'(vote_reject), 32'd0);
    chk("async total", 32'(total_votes), 32'd0);
    chk("async rd_count", 32'(rd_count), 32'd0);
    @(negedge clk);
    initializer = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      acks += int'(vote_ack) + int'(vote_reject);
    end
    chk("held after reset", 32'(acks), 32'd0);
    chk("held after reset total", 32'(total_votes), 32'd0);
    vote_cast = 1'b0;
    vote(1'b1, 4'd2, 1'b0, 4'd2, 1'b1, 1'b0, 1, 1, "post_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
